// File: rtl/sample_buffer_pkg.sv
// Shared types and default sizing for the sample capture/playback buffer.
package sample_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP   = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } buf_state_t;

    localparam int SB_DATA_W = 16;
    localparam int SB_DEPTH  = 87424;

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: write has priority over read, read data is registered.
module ram_sp
    import sample_buffer_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W,
    parameter int DEPTH  = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sample_buffer.sv
// Capture I/Q samples into RAM, then replay them (once or looped) as a
// valid/ready stream through a 2-entry skid buffer.
module sample_buffer
    import sample_buffer_pkg::*;
#(
    parameter  int DATA_W = SB_DATA_W,
    parameter  int DEPTH  = SB_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_cap,
    input  logic              start_play,
    input  logic              stop,
    input  logic              loop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [ADDR_W:0]   cap_len,
    output logic              full,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST_WR = (ADDR_W + 1)'(DEPTH - 1);

    buf_state_t        state, nstate;
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic              loop_r;
    logic              in_flight, in_flight_last;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              wr_en, rd_en, rd_at_end;

    logic [DATA_W:0]   sk_q [2];
    logic [1:0]        sk_cnt;
    logic              sk_head, sk_ne;
    logic              pop, pop_sk, push, room;

    assign s_ready   = (state == CAP);
    assign busy      = (state != IDLE);
    assign wr_en     = s_valid & s_ready;
    assign rd_at_end = (rd_ptr == cap_len - 1'b1);
    assign ram_addr  = (state == CAP) ? wr_ptr[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];

    // The RAM output register acts as a third queue slot: when the skid is
    // empty, the in-flight read is presented directly, giving t+2 latency.
    assign sk_ne   = (sk_cnt != 2'd0);
    assign m_valid = sk_ne | in_flight;
    assign m_data  = sk_ne ? sk_q[sk_head][DATA_W:1] : (in_flight ? rdata : '0);
    assign m_last  = sk_ne ? sk_q[sk_head][0] : (in_flight & in_flight_last);
    assign pop     = m_valid & m_ready;
    assign pop_sk  = pop & sk_ne;
    assign push    = in_flight & (sk_ne | ~m_ready);
    assign room    = ({1'b0, sk_cnt} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop});

    always_comb begin
        nstate = state;
        rd_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start_cap)       nstate = CAP;
                else if (start_play) nstate = PLAY;
            end
            CAP: begin
                if (stop || (wr_en && wr_ptr == LAST_WR)) nstate = IDLE;
            end
            PLAY: begin
                if (cap_len == '0) begin
                    nstate = IDLE;
                end else if (stop) begin
                    nstate = DRAIN;
                end else if (room) begin
                    rd_en = 1'b1;
                    if (rd_at_end && !loop_r) nstate = DRAIN;
                end
            end
            DRAIN: begin
                if (!sk_ne && !in_flight) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            done           <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cap_len        <= '0;
            full           <= 1'b0;
            loop_r         <= 1'b0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            sk_cnt         <= '0;
            sk_head        <= 1'b0;
        end else begin
            state <= nstate;
            done  <= (state != IDLE) && (nstate == IDLE);
            if (state == IDLE && start_cap) begin
                wr_ptr  <= '0;
                cap_len <= '0;
                full    <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cap_len <= wr_ptr + 1'b1;
                if (wr_ptr == LAST_WR) full <= 1'b1;
            end
            if (state == IDLE && !start_cap && start_play) begin
                rd_ptr <= '0;
                loop_r <= loop;
            end
            if (rd_en) rd_ptr <= rd_at_end ? '0 : rd_ptr + 1'b1;
            in_flight      <= rd_en;
            in_flight_last <= rd_en & rd_at_end;
            sk_cnt         <= sk_cnt + {1'b0, push} - {1'b0, pop_sk};
            sk_head        <= sk_head ^ pop_sk;
        end
    end

    always_ff @(posedge clk) begin
        if (push) sk_q[sk_head ^ sk_cnt[0]] <= {rdata, in_flight_last};
    end

    ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .re    (rd_en),
        .addr  (ram_addr),
        .wdata (s_data),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sample_buffer.sv
// Directed/randomised bench for sample_buffer (DEPTH=8) against a queue-style model.
module tb_sample_buffer;

    localparam int DW = 16;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_cap = 1'b0, start_play = 1'b0, stop = 1'b0, loop = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, m_valid, m_last, full, busy, done;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [3:0]    cap_len;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mdl [DP];
    int            mlen = 0;

    sample_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .start_cap(start_cap), .start_play(start_play),
        .stop(stop), .loop(loop), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .cap_len(cap_len), .full(full), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_data"},  32'(m_data),  0);
        check({tag, "_m_last"},  32'(m_last),  0);
        check({tag, "_cap_len"}, 32'(cap_len), 0);
        check({tag, "_full"},    32'(full),    0);
        check({tag, "_busy"},    32'(busy),    0);
        check({tag, "_done"},    32'(done),    0);
    endtask

    // Write exactly `want` samples with random s_valid gaps; stop lands with the last write.
    task automatic capture(input int want, input bit seq, input bit both);
        int wr = 0;
        int guard = 0;
        start_cap = 1'b1;
        start_play = both;
        @(negedge clk);
        start_cap = 1'b0;
        start_play = 1'b0;
        check("cap_ready_t1", 32'(s_ready), 1);
        while (wr < want && guard < 100) begin
            if (both) check("cap_no_play", 32'(m_valid), 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = seq ? DW'(wr + 1) : DW'($urandom);
            if (s_valid && s_ready) begin
                mdl[wr] = s_data;
                wr++;
            end
            stop = (wr == want);
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        stop = 1'b0;
        check("cap_guard", 32'(guard < 100), 1);
        check("cap_end_ready", 32'(s_ready), 0);
        check("cap_end_done", 32'(done), 1);
        check("cap_len", 32'(cap_len), 32'(want));
        check("cap_full", 32'(full), 0);
        mlen = want;
        @(negedge clk);
        check("cap_done_pulse", 32'(done), 0);
    endtask

    // mode 0: ready held high; 1: ready 1,0,0 repeating; 2: random ready.
    task automatic run_play(input int mode, input bit lp, input int stop_at);
        int hs = 0, cyc = 0, first = -1, after_stop = 0, done_cyc = -1, idx;
        bit stopped = 0;
        logic pv = 0, pr = 0, r;
        logic [DW-1:0] pd = '0;
        loop = lp;
        start_play = 1'b1;
        @(negedge clk);
        start_play = 1'b0;
        loop = 1'b0;
        check("play_t1_novalid", 32'(m_valid), 0);
        while (cyc < 300) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (pv && !pr) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", 32'(m_data), 32'(pd));
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            m_ready = r;
            if (m_valid && r) begin
                idx = (mlen > 0) ? hs % mlen : 0;
                check("play_data", 32'(m_data), 32'(mdl[idx]));
                check("play_last", 32'(m_last), 32'(idx == mlen - 1));
                if (first < 0) first = cyc;
                if (stopped) after_stop++;
                hs++;
            end
            pv = m_valid;
            pr = r;
            pd = m_data;
            stop = 1'b0;
            if (stop_at > 0 && hs == stop_at && !stopped) begin
                stop = 1'b1;
                stopped = 1;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        stop = 1'b0;
        check("play_timeout", 32'(done_cyc >= 0), 1);
        check("play_done_novalid", 32'(m_valid), 0);
        if (!lp) check("play_count", 32'(hs), 32'(mlen));
        if (lp) check("stop_tail_le2", 32'(after_stop <= 2), 1);
        if (mlen == 0) check("empty_done_cyc", 32'(done_cyc), 1);
        if (mlen > 0 && mode == 0) check("first_latency", 32'(first), 1);
        @(negedge clk);
        check("play_done_pulse", 32'(done), 0);
        check("play_idle", 32'(busy), 0);
    endtask

    initial begin
        int wr, dones;

        // Reset values
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_rst");

        // Capture 1..5, play once with ready held high, then with 1,0,0 backpressure
        capture(5, 1'b1, 1'b0);
        run_play(0, 1'b0, 0);
        run_play(1, 1'b0, 0);

        // Loop playback over 3 random samples, stopped mid-stream
        capture(3, 1'b0, 1'b0);
        run_play(0, 1'b1, 8);

        // Capture to full with s_valid held for 12 cycles
        start_cap = 1'b1;
        @(negedge clk);
        start_cap = 1'b0;
        wr = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            if (wr == DP) check("full_ready_low", 32'(s_ready), 0);
            s_valid = 1'b1;
            s_data = DW'($urandom);
            if (s_ready) begin
                if (wr < DP) mdl[wr] = s_data;
                wr++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (done) dones++;
        check("full_writes", 32'(wr), DP);
        check("full_flag", 32'(full), 1);
        check("full_cap_len", 32'(cap_len), DP);
        check("full_single_done", 32'(dones), 1);
        mlen = DP;
        run_play(2, 1'b0, 0);

        // Simultaneous start_cap/start_play: capture wins
        capture(2, 1'b0, 1'b1);
        run_play(2, 1'b0, 0);

        // Reset in the middle of playback
        capture(4, 1'b0, 1'b0);
        start_play = 1'b1;
        @(negedge clk);
        start_play = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_no_done", 32'(done), 0);
        @(negedge clk);
        check("rst_no_done2", 32'(done), 0);
        mlen = 0;
        run_play(0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_buffer.md
# sample_buffer

Parametrised sample capture/playback memory for the 802.11a front-end. It captures a stream of I/Q samples into on-chip RAM, then replays them as a valid/ready stream, once or looped. Replays are bounded by the captured length, with full-throughput backpressure handling. It sits between the ADC/sample source and the downstream sync/FFT path, and generalises the existing single-port capture RAM with modes, length tracking and streaming handshakes.

## Interface
- `DATA_W`, 16: sample width in bits.
- `DEPTH`, 87424: number of words stored.
- `ADDR_W`, `$clog2(DEPTH)`: address/length counter width (derived, not overridden).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_cap` in 1: pulse; begin capture at address 0.
- `start_play` in 1: pulse; begin playback from address 0.
- `stop` in 1: pulse; end the current capture or playback.
- `loop` in 1: sampled at `start_play`; 1 = replay continuously.
- `s_valid` in 1: capture input valid.
- `s_data` in `DATA_W`: capture sample.
- `s_ready` out 1: capture accepts; equals (state == CAP).
- `m_valid` out 1: playback output valid.
- `m_data` out `DATA_W`: playback sample.
- `m_last` out 1: marks the sample at address `cap_len-1`.
- `m_ready` in 1: downstream accepts.
- `cap_len` out `ADDR_W+1`: number of samples stored by the last capture.
- `full` out 1: last capture ended by reaching `DEPTH`.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse on every return to IDLE.

## Operation
- **States:** IDLE, CAP, PLAY, DRAIN.
- **IDLE:**
  - `start_cap` → CAP. Clears `full` and the write pointer.
  - Otherwise `start_play` → PLAY; `start_cap` wins if both are asserted.
  - Commands are ignored in any other state, except `stop`.
- **CAP:**
  - Each `s_valid & s_ready` writes `s_data` at `wr_ptr`, then increments `wr_ptr`. `cap_len` = `wr_ptr` after the write.
  - When a write lands at `DEPTH-1`, set `full` and go to IDLE.
  - `stop` → IDLE. A write in the same cycle as `stop` is still committed.
- **PLAY:**
  - Issue reads at `rd_ptr` from 0 to `cap_len-1`.
  - After the read of `cap_len-1`: if `loop`, wrap to 0; otherwise go to DRAIN.
  - `stop` → DRAIN; no further reads are issued.
  - If `cap_len == 0` at start → IDLE next cycle with `done`; no output.
- **DRAIN:** wait until the skid buffer is empty and no read is in flight, then → IDLE.
- **Output skid buffer:**
  - 2 entries, holding `{data, last}`.
  - A read is issued only when `occupancy + in_flight - pop < 2`, where `pop = m_valid & m_ready`.
  - Gives sustained 1 sample/cycle with `m_ready` held high, and no loss under backpressure.
- **Memory collisions:** none possible; capture and playback are mutually exclusive in time.
- **Reset values:** all outputs 0; `cap_len` = 0; pointers 0; skid buffer empty. Memory contents are not reset.
- **Reset mid-operation:** returns to IDLE immediately. No `done` pulse. Partial capture length is lost.

## Timing
- `start_cap` at cycle t → `s_ready` = 1 from t+1.
- Capture ends on the write at `DEPTH-1` (cycle w) or on `stop` (cycle w). In either case `s_ready` = 0 and `done` = 1 at w+1.
- `start_play` at t → first read issued at t+1 → earliest `m_valid` at t+2.
- RAM read latency is 1 cycle, registered.
- `m_data`/`m_last` are stable while `m_valid & !m_ready`.
- `done` is asserted in the first IDLE cycle after CAP/PLAY/DRAIN.
- Non-loop playback with `m_ready` = 1 produces exactly `cap_len` consecutive valid cycles, with `m_last` on the final one.

## Structure
- Package `sample_buffer_pkg`:
  - state enum `buf_state_t` {IDLE, CAP, PLAY, DRAIN};
  - `localparam` default `DATA_W`/`DEPTH`.
- Sub-module `ram_sp`:
  - parameters `DATA_W` and `DEPTH`;
  - single port, write-priority, registered read, no reset on the array.
- The FSM, pointers and skid buffer live in `sample_buffer`.

## Test plan
All scenarios use `DEPTH` = 8.
- **Capture 5, play once:** capture 5 samples 0x0001..0x0005, then `stop`, then `start_play` with `m_ready` = 1. Expect `cap_len` = 5, `full` = 0, and `m_data` 1..5 on consecutive cycles from t+2, `m_last` on 5, then `done`.
- **Capture to full:** capture with `s_valid` held high for 12 cycles. Expect exactly 8 writes, `full` = 1, `cap_len` = 8, `s_ready` low after the 8th write, and a single `done`.
- **Backpressure:** play with `m_ready` toggling 1,0,0,1,…. Expect the sequence 1..5 with no duplicates or gaps, and data held while stalled.
- **Loop and stop:** play with `loop` = 1, `cap_len` = 3, `m_ready` = 1. Expect 1,2,3,1,2,3,…, with `m_last` on every 3. After `stop`, expect at most 2 further samples, then `done`.
- **Reset mid-play:** assert `rst_n` = 0 during PLAY. Expect all outputs 0 and `cap_len` = 0 immediately, with no `done`. A subsequent `start_play` completes in 2 cycles with no output.
- **Simultaneous commands:** assert `start_cap` and `start_play` in the same IDLE cycle. Expect CAP to be entered; PLAY is not entered.
